// File: rtl/falling_piece_ctrl.sv
// falling_piece_ctrl
// Controller for the active falling tetromino. It spawns a piece from a 4x4
// mask, applies key shift/rotate and frame-rate gravity (with a soft-drop
// rate), and locks the piece when gravity is refused. Every candidate move is
// validated by the board-occupancy block through a cand_valid/cand_ack
// handshake. It also drives the per-pixel drawBlock for the moving piece.
//
// Ports
//   Clk, Reset_n            clock, asynchronous active-low reset
//   frame_clk               vsync-rate strobe, any duty cycle
//   keycode                 USB HID keycode, 0 = none
//   spawn, spawn_shape      new-piece request (level) and its 4x4 mask
//   cand_valid/x/y/shape    candidate placement presented to the board
//   cand_ack, cand_ok       board verdict, cand_ok sampled with cand_ack
//   lock                    one-cycle pulse, piece committed at cand_*
//   game_over               sticky, spawn position was refused
//   blockstate              current piece mask
//   DrawX, DrawY, drawBlock pixel query for the moving piece
module falling_piece_ctrl #(
    parameter int         GRID_W         = 10,
    parameter int         GRID_H         = 20,
    parameter int         CELL_LOG2      = 4,
    parameter logic [9:0] ORIGIN_X       = 10'd240,
    parameter logic [9:0] ORIGIN_Y       = 10'd80,
    parameter int         GRAVITY_FRAMES = 30,
    parameter int         FAST_FRAMES    = 3
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic        spawn,
    input  logic [15:0] spawn_shape,
    output logic        cand_valid,
    output logic [5:0]  cand_x,
    output logic [5:0]  cand_y,
    output logic [15:0] cand_shape,
    input  logic        cand_ack,
    input  logic        cand_ok,
    output logic        lock,
    output logic        game_over,
    output logic [15:0] blockstate,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        drawBlock
);

    // Candidate coordinates are 6-bit signed; larger boards cannot be encoded.
    if (GRID_W > 32 || GRID_H > 32) begin : g_grid_too_large
        $error("falling_piece_ctrl: grid does not fit 6-bit candidate fields");
    end

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    localparam logic [5:0] SPAWN_X = 6'((GRID_W - 4) / 2);

    localparam int CNT_MAX = (GRAVITY_FRAMES > FAST_FRAMES) ? GRAVITY_FRAMES : FAST_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int CNT_W1  = CNT_W + 1;

    localparam logic [1:0] ACT_ROT   = 2'd0;
    localparam logic [1:0] ACT_LEFT  = 2'd1;
    localparam logic [1:0] ACT_RIGHT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN_REQ,
        S_FALL,
        S_KEY_REQ,
        S_GRAV_REQ,
        S_LOCK
    } state_t;

    state_t             r_state;
    logic               r_fclk_sync;
    logic               r_fclk_prev;
    logic               r_frame_tick;
    logic [CNT_W-1:0]   r_grav_cnt;
    logic               r_grav_due;
    logic               r_key_used;
    logic [1:0]         r_key_act;
    logic [5:0]         r_x;
    logic [5:0]         r_y;
    logic [15:0]        r_shape;
    logic               r_live;
    logic               r_cand_valid;
    logic [5:0]         r_cand_x;
    logic [5:0]         r_cand_y;
    logic [15:0]        r_cand_shape;
    logic               r_lock;
    logic               r_game_over;

    logic               w_key_wad;
    logic               w_key_pending;
    logic [CNT_W:0]     w_cnt_inc;
    logic [CNT_W:0]     w_limit;
    logic               w_grav_due;
    logic [15:0]        w_rot;

    assign w_key_wad     = (keycode == KEY_W) || (keycode == KEY_A) || (keycode == KEY_D);
    assign w_key_pending = w_key_wad && !r_key_used;

    // Limit follows the S key at compare time, so a rate change mid-count
    // applies on the very next tick.
    assign w_cnt_inc  = {1'b0, r_grav_cnt} + CNT_W1'(1);
    assign w_limit    = (keycode == KEY_S) ? CNT_W1'(FAST_FRAMES) : CNT_W1'(GRAVITY_FRAMES);
    assign w_grav_due = (w_cnt_inc >= w_limit);

    // Clockwise rotation: new[r][c] = old[3-c][r].
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rot
            assign w_rot[gi] = r_shape[(3 - (gi % 4)) * 4 + (gi / 4)];
        end
    endgenerate

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= S_IDLE;
            r_fclk_sync  <= 1'b0;
            r_fclk_prev  <= 1'b0;
            r_frame_tick <= 1'b0;
            r_grav_cnt   <= '0;
            r_grav_due   <= 1'b0;
            r_key_used   <= 1'b0;
            r_key_act    <= ACT_ROT;
            r_x          <= '0;
            r_y          <= '0;
            r_shape      <= '0;
            r_live       <= 1'b0;
            r_cand_valid <= 1'b0;
            r_cand_x     <= '0;
            r_cand_y     <= '0;
            r_cand_shape <= '0;
            r_lock       <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_fclk_sync  <= frame_clk;
            r_fclk_prev  <= r_fclk_sync;
            r_frame_tick <= r_fclk_sync & ~r_fclk_prev;
            r_lock       <= 1'b0;

            // A released (non W/A/D) key re-arms the one-action-per-press flag.
            if (r_frame_tick && !w_key_wad) begin
                r_key_used <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (spawn && !r_game_over) begin
                        r_state <= S_SPAWN_REQ;
                    end
                end

                S_SPAWN_REQ: begin
                    if (!r_cand_valid) begin
                        r_cand_valid <= 1'b1;
                        r_cand_x     <= SPAWN_X;
                        r_cand_y     <= '0;
                        r_cand_shape <= spawn_shape;
                    end else if (cand_ack) begin
                        r_cand_valid <= 1'b0;
                        if (cand_ok) begin
                            r_x        <= r_cand_x;
                            r_y        <= r_cand_y;
                            r_shape    <= r_cand_shape;
                            r_live     <= 1'b1;
                            r_grav_cnt <= '0;
                            r_state    <= S_FALL;
                        end else begin
                            r_game_over <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                end

                S_FALL: begin
                    if (r_frame_tick) begin
                        r_grav_cnt <= w_grav_due ? '0 : w_cnt_inc[CNT_W-1:0];
                        r_grav_due <= w_grav_due;
                        if (w_key_pending) begin
                            r_key_used <= 1'b1;
                            if (keycode == KEY_W) begin
                                r_key_act <= ACT_ROT;
                            end else if (keycode == KEY_A) begin
                                r_key_act <= ACT_LEFT;
                            end else begin
                                r_key_act <= ACT_RIGHT;
                            end
                            r_state <= S_KEY_REQ;
                        end else if (w_grav_due) begin
                            r_state <= S_GRAV_REQ;
                        end
                    end
                end

                S_KEY_REQ: begin
                    if (!r_cand_valid) begin
                        r_cand_valid <= 1'b1;
                        r_cand_y     <= r_y;
                        case (r_key_act)
                            ACT_ROT: begin
                                r_cand_x     <= r_x;
                                r_cand_shape <= w_rot;
                            end
                            ACT_LEFT: begin
                                r_cand_x     <= r_x - 6'd1;
                                r_cand_shape <= r_shape;
                            end
                            default: begin
                                r_cand_x     <= r_x + 6'd1;
                                r_cand_shape <= r_shape;
                            end
                        endcase
                    end else if (cand_ack) begin
                        r_cand_valid <= 1'b0;
                        if (cand_ok) begin
                            r_x     <= r_cand_x;
                            r_shape <= r_cand_shape;
                        end
                        r_state <= r_grav_due ? S_GRAV_REQ : S_FALL;
                    end
                end

                S_GRAV_REQ: begin
                    if (!r_cand_valid) begin
                        // Built from the piece registers so a key move
                        // committed just before is already included.
                        r_cand_valid <= 1'b1;
                        r_cand_x     <= r_x;
                        r_cand_y     <= r_y + 6'd1;
                        r_cand_shape <= r_shape;
                    end else if (cand_ack) begin
                        r_cand_valid <= 1'b0;
                        if (cand_ok) begin
                            r_y     <= r_cand_y;
                            r_state <= S_FALL;
                        end else begin
                            // Present the resting position with the lock pulse.
                            r_lock       <= 1'b1;
                            r_cand_x     <= r_x;
                            r_cand_y     <= r_y;
                            r_cand_shape <= r_shape;
                            r_state      <= S_LOCK;
                        end
                    end
                end

                S_LOCK: begin
                    r_live  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cand_valid = r_cand_valid;
    assign cand_x     = r_cand_x;
    assign cand_y     = r_cand_y;
    assign cand_shape = r_cand_shape;
    assign lock       = r_lock;
    assign game_over  = r_game_over;
    assign blockstate = r_shape;

    // Pixel to piece-local cell; 12-bit signed so the offset can go negative.
    logic [9:0]         w_px;
    logic [9:0]         w_py;
    logic [9:0]         w_cell_x;
    logic [9:0]         w_cell_y;
    logic signed [11:0] w_xs;
    logic signed [11:0] w_ys;
    logic signed [11:0] w_c;
    logic signed [11:0] w_r;
    logic               w_in_window;

    assign w_px     = DrawX - ORIGIN_X;
    assign w_py     = DrawY - ORIGIN_Y;
    assign w_cell_x = w_px >> CELL_LOG2;
    assign w_cell_y = w_py >> CELL_LOG2;
    assign w_xs     = {{6{r_x[5]}}, r_x};
    assign w_ys     = {{6{r_y[5]}}, r_y};
    assign w_c      = $signed({2'b00, w_cell_x}) - w_xs;
    assign w_r      = $signed({2'b00, w_cell_y}) - w_ys;

    assign w_in_window = (DrawX >= ORIGIN_X) && (DrawY >= ORIGIN_Y) &&
                         (w_c[11:2] == 10'd0) && (w_r[11:2] == 10'd0);

    // r_live is only set between a spawn commit and the end of LOCK, so the
    // piece is never drawn while IDLE.
    assign drawBlock = r_live && w_in_window && r_shape[{w_r[1:0], w_c[1:0]}];

endmodule

// File: tb/tb_falling_piece_ctrl.sv
// Self-checking bench for falling_piece_ctrl: the bench plays the board
// (bounds check plus random refusals) and keeps a cell-level model of the
// piece, the gravity count and the one-action-per-press flag.
module tb_falling_piece_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic [7:0]  keycode = 8'h00;
    logic        spawn = 1'b0;
    logic [15:0] spawn_shape = 16'h0000;
    logic        cand_valid;
    logic [5:0]  cand_x;
    logic [5:0]  cand_y;
    logic [15:0] cand_shape;
    logic        cand_ack = 1'b0;
    logic        cand_ok = 1'b0;
    logic        lock;
    logic        game_over;
    logic [15:0] blockstate;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic        drawBlock;

    always #5 Clk = ~Clk;

    falling_piece_ctrl dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .keycode     (keycode),
        .spawn       (spawn),
        .spawn_shape (spawn_shape),
        .cand_valid  (cand_valid),
        .cand_x      (cand_x),
        .cand_y      (cand_y),
        .cand_shape  (cand_shape),
        .cand_ack    (cand_ack),
        .cand_ok     (cand_ok),
        .lock        (lock),
        .game_over   (game_over),
        .blockstate  (blockstate),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .drawBlock   (drawBlock)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          mx;
    int          my;
    logic [15:0] mshape;
    bit          mlive;
    bit          mkey_used;
    int          mcnt;

    logic [15:0] shapes [8] = '{16'h0066, 16'h00F0, 16'h0033, 16'h0072,
                                16'h0036, 16'h0063, 16'h0074, 16'h0071};
    logic [7:0]  keys   [8] = '{8'h00, 8'h1A, 8'h04, 8'h07, 8'h16, 8'h16, 8'h05, 8'h00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rot_cw(input logic [15:0] s);
        logic [15:0] n;
        n = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                n[r*4+c] = s[(3-c)*4+r];
        return n;
    endfunction

    function automatic bit fits(input int x, input int y, input logic [15:0] s);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (s[r*4+c] && (x+c < 0 || x+c >= 10 || y+r < 0 || y+r >= 20))
                    return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_draw(input int dx, input int dy);
        if (!mlive || dx < 240 || dy < 80) return 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (mshape[r*4+c]) begin
                    int x0 = 240 + (mx + c) * 16;
                    int y0 = 80 + (my + r) * 16;
                    if (dx >= x0 && dx < x0 + 16 && dy >= y0 && dy < y0 + 16)
                        return 1'b1;
                end
        return 1'b0;
    endfunction

    // Act as the board for one expected request.
    task automatic serve(input string tag, input int ex, input int ey,
                         input logic [15:0] es, input bit ok);
        int n = 0;
        int d;
        logic [5:0] ex6;
        logic [5:0] ey6;
        ex6 = ex[5:0];
        ey6 = ey[5:0];
        while (cand_valid !== 1'b1 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        check({tag, "_req_seen"}, 32'(cand_valid), 32'd1);
        if (cand_valid !== 1'b1) return;
        d = $urandom_range(0, 2);
        repeat (d) @(negedge Clk);
        check({tag, "_x"}, 32'(cand_x), 32'(ex6));
        check({tag, "_y"}, 32'(cand_y), 32'(ey6));
        check({tag, "_shape"}, 32'(cand_shape), 32'(es));
        $display("%s x=%0d y=%0d shape=%h ok=%0d", tag, ex, ey, es, ok);
        cand_ack = 1'b1;
        cand_ok  = ok;
        @(negedge Clk);
        cand_ack = 1'b0;
        cand_ok  = 1'b0;
        check({tag, "_valid_drop"}, 32'(cand_valid), 32'd0);
    endtask

    task automatic model_reset();
        mlive = 0; mkey_used = 0; mcnt = 0; mx = 0; my = 0; mshape = '0;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        keycode = 8'h00;
        spawn   = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        @(negedge Clk);
    endtask

    task automatic spawn_piece();
        bit ok;
        do begin
            logic [15:0] s;
            int n;
            bit seen;
            s  = shapes[$urandom_range(0, 7)];
            ok = ($urandom_range(0, 15) != 0);
            spawn_shape = s;
            spawn = 1'b1;
            serve("spawn", 3, 0, s, ok);
            spawn = 1'b0;
            if (ok) begin
                mx = 3; my = 0; mshape = s; mlive = 1; mcnt = 0;
                check("spawn_blockstate", 32'(blockstate), 32'(s));
            end else begin
                check("game_over_set", 32'(game_over), 32'd1);
                spawn = 1'b1;
                seen = 1'b0;
                for (n = 0; n < 15; n++) begin
                    @(negedge Clk);
                    seen |= cand_valid;
                end
                spawn = 1'b0;
                check("game_over_spawn_ignored", 32'(seen), 32'd0);
                check("game_over_held", 32'(game_over), 32'd1);
                DrawX = 10'd288; DrawY = 10'd80;
                #1;
                check("game_over_draw", 32'(drawBlock), 32'd0);
                $display("game over seen, resetting");
                do_reset();
            end
        end while (!ok);
    endtask

    task automatic draw_probe(input string tag);
        int col, row, dx, dy;
        col = mx + $urandom_range(0, 5) - 1;
        row = my + $urandom_range(0, 5) - 1;
        dx  = 240 + col * 16 + $urandom_range(0, 15);
        dy  = 80 + row * 16 + $urandom_range(0, 15);
        DrawX = dx[9:0];
        DrawY = dy[9:0];
        #1;
        check(tag, 32'(drawBlock), 32'(model_draw(dx, dy)));
    endtask

    task automatic do_frame(input logic [7:0] kc);
        bit wad, due, pending, ok;
        int lim, nx, dx, dy;
        logic [15:0] ns;
        keycode   = kc;
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;

        wad = (kc == 8'h1A) || (kc == 8'h04) || (kc == 8'h07);
        if (!wad) mkey_used = 0;
        lim = (kc == 8'h16) ? 3 : 30;
        due = (mcnt + 1 >= lim);
        mcnt = due ? 0 : mcnt + 1;
        pending = wad && !mkey_used;

        if (pending) begin
            mkey_used = 1;
            nx = mx;
            ns = mshape;
            if (kc == 8'h1A) ns = rot_cw(mshape);
            else if (kc == 8'h04) nx = mx - 1;
            else nx = mx + 1;
            ok = fits(nx, my, ns) && ($urandom_range(0, 7) != 0);
            serve("key", nx, my, ns, ok);
            if (ok) begin
                mx = nx;
                mshape = ns;
            end
            check("key_blockstate", 32'(blockstate), 32'(mshape));
        end
        if (due) begin
            ok = fits(mx, my + 1, mshape) && ($urandom_range(0, 14) != 0);
            serve("grav", mx, my + 1, mshape, ok);
            if (ok) begin
                my = my + 1;
            end else begin
                logic [5:0] x6, y6;
                x6 = mx[5:0];
                y6 = my[5:0];
                check("lock_pulse", 32'(lock), 32'd1);
                check("lock_x", 32'(cand_x), 32'(x6));
                check("lock_y", 32'(cand_y), 32'(y6));
                check("lock_shape", 32'(cand_shape), 32'(mshape));
                $display("lock at x=%0d y=%0d", mx, my);
                @(negedge Clk);
                check("lock_single", 32'(lock), 32'd0);
                mlive = 0;
                for (int i = 0; i < 16; i++)
                    if (mshape[i]) begin
                        dx = 240 + (mx + i % 4) * 16 + 5;
                        dy = 80 + (my + i / 4) * 16 + 5;
                        break;
                    end
                DrawX = dx[9:0];
                DrawY = dy[9:0];
                #1;
                check("idle_draw", 32'(drawBlock), 32'(model_draw(dx, dy)));
                @(negedge Clk);
                check("lock_once", 32'(lock), 32'd0);
                spawn_piece();
            end
        end
        if (!pending && !due) begin
            bit seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge Clk);
                seen |= cand_valid;
            end
            check("no_request", 32'(seen), 32'd0);
        end
        if (mlive) begin
            draw_probe("draw_a");
            draw_probe("draw_b");
        end
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        logic [7:0] kc;
        int n;
        model_reset();
        repeat (3) @(negedge Clk);
        check("rst_cand_valid", 32'(cand_valid), 32'd0);
        check("rst_lock", 32'(lock), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_blockstate", 32'(blockstate), 32'd0);
        check("rst_cand_x", 32'(cand_x), 32'd0);
        check("rst_cand_y", 32'(cand_y), 32'd0);
        check("rst_cand_shape", 32'(cand_shape), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // Directed spawn with mask bit 0 set, then the edge pixels of cell (3,0).
        spawn_shape = 16'h0033;
        spawn = 1'b1;
        serve("spawn", 3, 0, 16'h0033, 1'b1);
        spawn = 1'b0;
        mx = 3; my = 0; mshape = 16'h0033; mlive = 1; mcnt = 0;
        check("spawn_blockstate", 32'(blockstate), 32'h0033);
        DrawX = 10'd288; DrawY = 10'd80;
        #1;
        check("draw_288_80", 32'(drawBlock), 32'd1);
        DrawX = 10'd287;
        #1;
        check("draw_287_80", 32'(drawBlock), 32'd0);
        @(negedge Clk);

        kc = 8'h00;
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 1) == 0) kc = keys[$urandom_range(0, 7)];
            do_frame(kc);
        end

        // Reset while a candidate is held.
        do_reset();
        spawn_shape = 16'h0066;
        spawn = 1'b1;
        n = 0;
        while (cand_valid !== 1'b1 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        check("rst_mid_req_seen", 32'(cand_valid), 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        check("rst_mid_cand_valid", 32'(cand_valid), 32'd0);
        check("rst_mid_lock", 32'(lock), 32'd0);
        check("rst_mid_game_over", 32'(game_over), 32'd0);
        check("rst_mid_blockstate", 32'(blockstate), 32'd0);
        check("rst_mid_cand_x", 32'(cand_x), 32'd0);
        check("rst_mid_cand_shape", 32'(cand_shape), 32'd0);
        check("rst_mid_draw", 32'(drawBlock), 32'd0);
        spawn = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        @(negedge Clk);

        // Forced spawn refusal.
        spawn_shape = 16'h00F0;
        spawn = 1'b1;
        serve("spawn", 3, 0, 16'h00F0, 1'b0);
        check("final_game_over", 32'(game_over), 32'd1);
        repeat (10) @(negedge Clk);
        check("final_no_request", 32'(cand_valid), 32'd0);
        check("final_game_over_held", 32'(game_over), 32'd1);
        spawn = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/falling_piece_ctrl.md
# falling_piece_ctrl

- Parametrised controller for the active falling tetromino on a cell grid:
  - spawns a piece from a 4x4 shape mask;
  - applies keyboard shift/rotate and frame-rate gravity, with a soft-drop rate;
  - locks the piece when gravity is refused.
- Every candidate move is validated through a request/acknowledge handshake with the board-occupancy block.
- Sits between the keyboard keycode path and the board/colour mapper, and drives the per-pixel `drawBlock` for the moving piece.

## Interface
Parameters:
- `GRID_W`, 10: board width in cells.
- `GRID_H`, 20: board height in cells.
- `CELL_LOG2`, 4: log2 of cell size in pixels (16 px cells).
- `ORIGIN_X`, 10'd240: pixel X of board cell (0,0).
- `ORIGIN_Y`, 10'd80: pixel Y of board cell (0,0).
- `GRAVITY_FRAMES`, 30: frame ticks per gravity step, normal rate.
- `FAST_FRAMES`, 3: frame ticks per gravity step while soft-drop is held.

Ports:
- `Clk` in 1: system clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `frame_clk` in 1: vertical-sync-rate strobe (any duty cycle).
- `keycode` in 8: current USB HID keycode, 0 = none.
- `spawn` in 1: level; request a new piece while in IDLE.
- `spawn_shape` in 16: 4x4 mask of the new piece, bit r*4+c = row r, col c.
- `cand_valid` out 1: candidate placement presented to the board.
- `cand_x` out 6: signed candidate column of mask col 0.
- `cand_y` out 6: signed candidate row of mask row 0.
- `cand_shape` out 16: candidate mask.
- `cand_ack` in 1: board has evaluated the candidate.
- `cand_ok` in 1: candidate is free and in bounds; sampled with `cand_ack`.
- `lock` out 1: one-cycle pulse; piece committed at `cand_x`/`cand_y`/`cand_shape`.
- `game_over` out 1: sticky; spawn position was refused.
- `blockstate` out 16: current piece mask.
- `DrawX`, `DrawY` in 10 each: current pixel.
- `drawBlock` out 1: combinational; pixel lies in an occupied cell of the active piece.

## Operation
- **Frame tick.** `frame_tick` is a registered rising-edge detect of `frame_clk`, one cycle wide.
- **States:**
  - IDLE -> SPAWN_REQ when `spawn` = 1 and `game_over` = 0.
  - SPAWN_REQ: candidate is (`(GRID_W-4)/2`, 0, `spawn_shape`).
    - ok: latch the piece, clear the gravity counter, go to FALL.
    - refused: set `game_over`, go to IDLE.
  - FALL: waits for `frame_tick`.
    - On a tick, if a key action is pending -> KEY_REQ.
    - Else, if gravity is due -> GRAV_REQ.
    - Else stay in FALL.
  - KEY_REQ: one action, chosen by priority:
    - W 8'h1A rotates CW: `new[r][c] = old[3-c][r]`.
    - A 8'h04 shifts x-1.
    - D 8'h07 shifts x+1.
    - ok: commit. Refused: discard.
    - Next state is GRAV_REQ if gravity is due, else FALL.
  - GRAV_REQ: candidate is y+1.
    - ok: commit, go to FALL.
    - Refused: go to LOCK.
  - LOCK: `lock` = 1 for one cycle, presenting the current position and shape; next state IDLE.
- **One action per key press.** Flag `key_used` is set when a W/A/D action is issued. It clears on any tick where `keycode` is none of W/A/D. No action is issued while it is set.
- **Gravity counter.** Increments on each `frame_tick` in FALL. Gravity is due when count+1 >= limit; the counter then resets to 0.
  - limit = `FAST_FRAMES` while S 8'h16 is held, else `GRAVITY_FRAMES`.
  - Switching rate mid-count takes effect on the next compare.
- **Candidate fields.** `cand_x`/`cand_y` are 6-bit two's complement, range -3..GRID_W-1. Bounds and occupancy checking belong to the board; this block never clamps.
- **Draw.**
  - px = DrawX - ORIGIN_X, py = DrawY - ORIGIN_Y.
  - c = (px >> CELL_LOG2) - x, r = (py >> CELL_LOG2) - y.
  - `drawBlock` = 1 iff DrawX >= ORIGIN_X, DrawY >= ORIGIN_Y, 0 <= c,r <= 3, and `blockstate[r*4+c]` = 1.
  - `drawBlock` = 0 in IDLE, including after game over.

## Timing
- **Reset values:** state IDLE; `cand_valid`, `lock`, `game_over`, `blockstate`, `cand_*` = 0; counter and `key_used` = 0.
- **Handshake:**
  - `cand_valid` rises the cycle after the state enters a *_REQ state.
  - The candidate is held stable until the cycle `cand_ack` = 1 is sampled. `cand_valid` falls the next cycle.
  - The board may acknowledge the same cycle `cand_valid` rises, or any later cycle.
  - `cand_ack` outside a *_REQ state is ignored.
- **Latency.** `frame_tick` lags a `frame_clk` rise by 2 cycles. Ticks arriving while in a *_REQ state or LOCK are dropped; they are not queued.
- **Commit timing.** A commit updates the piece registers, and therefore `blockstate` and `drawBlock`, on the edge after the acknowledge.
- **`lock`** asserts exactly once per piece, 1 cycle after the refused gravity acknowledge.
- **Reset mid-handshake:** everything returns to reset values immediately; no `lock` is emitted.

## Test plan
- **Spawn accepted:** `spawn`=1, `spawn_shape`=16'h0066, board acks ok -> `cand_x`=3, `cand_y`=0; `blockstate`=16'h0066; state FALL.
- **Gravity:** hold `keycode`=0 for 30 frame ticks -> exactly one GRAV_REQ with `cand_y`=1; ok -> y=1. Hold S instead -> a request every 3 ticks.
- **Key once per press:**
  - Hold A for 10 ticks, all ok -> x goes from 3 to 2 only.
  - Release for 1 tick, press D -> x=3.
  - A refused shift leaves x unchanged.
- **Rotation:** shape 16'h00F0 (row 1), W with ok -> `cand_shape`=16'h4444; `blockstate` updates after the ack.
- **Landing:** GRAV_REQ refused at y=17 -> single-cycle `lock` with `cand_y`=17; state IDLE; `drawBlock`=0.
- **Game over and draw/reset:**
  - Spawn refused -> `game_over`=1, held; further `spawn` ignored.
  - With the piece at (3,0) and mask bit 0 set, pixel (288,80) gives `drawBlock`=1 and pixel (287,80) gives 0.
  - `Reset_n` low during a held `cand_valid` -> all outputs 0 asynchronously.
